// File: rtl/div_seq_ctrl.sv
// Sequencer around the 32-bit unsigned divider core: signed-to-magnitude conversion,
// core handshake with timeout, sign correction and HI/LO write-back.
module div_seq_ctrl #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned TIMEOUT = 40
) (
   input  logic             clock,
   input  logic             clear_n,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             core_start,
   output logic [WIDTH-1:0] core_dividend,
   output logic [WIDTH-1:0] core_divisor,
   input  logic             core_done,
   input  logic [WIDTH-1:0] core_quotient,
   input  logic [WIDTH-1:0] core_remainder,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic             timeout_err
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_PREP, S_ISSUE, S_WAIT, S_FIX, S_WRITE, S_ZERO
   } state_t;

   state_t           state, state_d;
   logic [WIDTH-1:0] op_q, op_q_d, op_m, op_m_d;
   logic             op_signed, op_signed_d;
   logic             q_sign, q_sign_d, r_sign, r_sign_d;
   logic [WIDTH-1:0] quo, quo_d, rem, rem_d;
   logic [CW-1:0]    cnt, cnt_d, cnt_inc;
   logic [WIDTH-1:0] core_dividend_d, core_divisor_d, hi_d, lo_d;
   logic             core_start_d, busy_d, done_d, div_zero_d, timeout_err_d;
   logic             neg_q, neg_m;

   assign neg_q   = op_signed & op_q[WIDTH-1];
   assign neg_m   = op_signed & op_m[WIDTH-1];
   assign cnt_inc = cnt + CW'(1);

   // Next-state and next-output logic
   always_comb begin
      state_d         = state;
      op_q_d          = op_q;
      op_m_d          = op_m;
      op_signed_d     = op_signed;
      q_sign_d        = q_sign;
      r_sign_d        = r_sign;
      quo_d           = quo;
      rem_d           = rem;
      cnt_d           = cnt;
      core_dividend_d = core_dividend;
      core_divisor_d  = core_divisor;
      hi_d            = hi;
      lo_d            = lo;
      core_start_d    = 1'b0;
      done_d          = 1'b0;
      div_zero_d      = div_zero;
      timeout_err_d   = timeout_err;

      case (state)
         S_IDLE: begin
            if (start) begin
               op_q_d        = dividend;
               op_m_d        = divisor;
               op_signed_d   = signed_op;
               div_zero_d    = 1'b0;
               timeout_err_d = 1'b0;
               state_d       = S_PREP;
            end
         end
         S_PREP: begin
            core_dividend_d = neg_q ? (~op_q + WIDTH'(1)) : op_q;
            core_divisor_d  = neg_m ? (~op_m + WIDTH'(1)) : op_m;
            q_sign_d        = neg_q ^ neg_m;
            r_sign_d        = neg_q;
            if (op_m == '0) begin
               state_d = S_ZERO;
            end else begin
               core_start_d = 1'b1;
               state_d      = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (core_done) begin
               quo_d   = core_quotient;
               rem_d   = core_remainder;
               state_d = S_FIX;
            end else if (cnt_inc == CW'(TIMEOUT)) begin
               // Hung core: abort without touching hi/lo
               cnt_d         = cnt_inc;
               timeout_err_d = 1'b1;
               done_d        = 1'b1;
               state_d       = S_WRITE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_FIX: begin
            lo_d    = q_sign ? (~quo + WIDTH'(1)) : quo;
            hi_d    = r_sign ? (~rem + WIDTH'(1)) : rem;
            done_d  = 1'b1;
            state_d = S_WRITE;
         end
         S_ZERO: begin
            lo_d       = '1;
            hi_d       = op_q;
            div_zero_d = 1'b1;
            done_d     = 1'b1;
            state_d    = S_WRITE;
         end
         S_WRITE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and registered outputs
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state         <= S_IDLE;
         op_q          <= '0;
         op_m          <= '0;
         op_signed     <= 1'b0;
         q_sign        <= 1'b0;
         r_sign        <= 1'b0;
         quo           <= '0;
         rem           <= '0;
         cnt           <= '0;
         core_dividend <= '0;
         core_divisor  <= '0;
         hi            <= '0;
         lo            <= '0;
         core_start    <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         div_zero      <= 1'b0;
         timeout_err   <= 1'b0;
      end else begin
         state         <= state_d;
         op_q          <= op_q_d;
         op_m          <= op_m_d;
         op_signed     <= op_signed_d;
         q_sign        <= q_sign_d;
         r_sign        <= r_sign_d;
         quo           <= quo_d;
         rem           <= rem_d;
         cnt           <= cnt_d;
         core_dividend <= core_dividend_d;
         core_divisor  <= core_divisor_d;
         hi            <= hi_d;
         lo            <= lo_d;
         core_start    <= core_start_d;
         busy          <= busy_d;
         done          <= done_d;
         div_zero      <= div_zero_d;
         timeout_err   <= timeout_err_d;
      end
   end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl with a behavioural divider core of programmable latency.
module tb_div_seq_ctrl;

   logic        clock = 1'b0;
   logic        clear_n = 1'b1;
   logic        start = 1'b0;
   logic        signed_op = 1'b0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        core_start;
   logic [31:0] core_dividend, core_divisor;
   logic        core_done = 1'b0;
   logic [31:0] core_quotient = '0;
   logic [31:0] core_remainder = '0;
   logic [31:0] hi, lo;
   logic        busy, done, div_zero, timeout_err;

   int tests = 0;
   int errors = 0;
   int core_n = 1;
   int pend = 0;
   int cs_count = 0;
   logic inject = 1'b0;

   div_seq_ctrl #(.WIDTH(32), .TIMEOUT(40)) dut (
      .clock(clock), .clear_n(clear_n), .start(start), .signed_op(signed_op),
      .dividend(dividend), .divisor(divisor), .core_start(core_start),
      .core_dividend(core_dividend), .core_divisor(core_divisor),
      .core_done(core_done), .core_quotient(core_quotient),
      .core_remainder(core_remainder), .hi(hi), .lo(lo), .busy(busy),
      .done(done), .div_zero(div_zero), .timeout_err(timeout_err)
   );

   always #5 clock = ~clock;

   // Core model: core_done arrives N cycles after core_start (N=0 means never)
   always @(negedge clock) begin
      logic nxt;
      nxt = 1'b0;
      if (pend > 0) begin
         pend = pend - 1;
         if (pend == 0) begin
            nxt            = 1'b1;
            core_quotient  = core_dividend / core_divisor;
            core_remainder = core_dividend % core_divisor;
         end
      end
      if (inject) begin
         nxt    = 1'b1;
         inject = 1'b0;
      end
      if (core_start) begin
         cs_count = cs_count + 1;
         if (core_n > 0) pend = core_n;
      end
      core_done = nxt;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic sg, input logic [31:0] a, b,
                         input int n, input logic [31:0] emq, emm, elo, ehi,
                         input logic edz, eto, input int edone);
      int cs_cyc, dn_cyc, cs0, busy_low;
      logic [31:0] cdvd, cdvs;
      cs_cyc = -1; dn_cyc = -1; busy_low = 0; cdvd = '0; cdvs = '0;
      @(negedge clock);
      signed_op = sg; dividend = a; divisor = b; core_n = n; start = 1'b1;
      cs0 = cs_count;
      @(posedge clock);
      #1 start = 1'b0;
      for (int c = 1; c <= 200 && dn_cyc < 0; c++) begin
         @(negedge clock);
         if (!busy) busy_low++;
         if (core_start && cs_cyc < 0) begin
            cs_cyc = c; cdvd = core_dividend; cdvs = core_divisor;
         end
         if (done) dn_cyc = c;
      end
      if (dn_cyc < 0) begin
         check({tag, "_done_seen"}, 32'd0, 32'd1);
      end else begin
         check({tag, "_busy_gap"}, 32'(busy_low), 32'd0);
         if (edone >= 0) check({tag, "_done_cyc"}, 32'(dn_cyc), 32'(edone));
         check({tag, "_lo"}, lo, elo);
         check({tag, "_hi"}, hi, ehi);
         check({tag, "_div_zero"}, 32'(div_zero), 32'(edz));
         check({tag, "_timeout"}, 32'(timeout_err), 32'(eto));
      end
      if (b == 32'd0) begin
         check({tag, "_no_core_start"}, 32'(cs_count - cs0), 32'd0);
      end else begin
         check({tag, "_cs_cyc"}, 32'(cs_cyc), 32'd2);
         check({tag, "_core_dvd"}, cdvd, emq);
         check({tag, "_core_dvs"}, cdvs, emm);
      end
      @(negedge clock);
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      check({tag, "_idle_done"}, 32'(done), 32'd0);
      check({tag, "_lo_hold"}, lo, elo);
   endtask

   initial begin
      int first_cs, second_cs, cs0;
      #2 clear_n = 1'b0;
      #1;
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_core_start", 32'(core_start), 32'd0);
      check("rst_flags", {30'd0, div_zero, timeout_err}, 32'd0);
      repeat (2) @(negedge clock);
      clear_n = 1'b1;

      run_op("u100_7",   1'b0, 32'd100,        32'd7,        32, 32'd100,        32'd7,  32'd14,       32'd2,        1'b0, 1'b0, 36);
      run_op("sm100_7",  1'b1, 32'hFFFFFF9C,   32'd7,        5,  32'd100,        32'd7,  32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0, 9);
      run_op("s100_m7",  1'b1, 32'd100,        32'hFFFFFFF9, 3,  32'd100,        32'd7,  32'hFFFFFFF2, 32'd2,        1'b0, 1'b0, 7);
      run_op("smin_m1",  1'b1, 32'h80000000,   32'hFFFFFFFF, 2,  32'h80000000,   32'd1,  32'h80000000, 32'd0,        1'b0, 1'b0, 6);
      run_op("u_msb",    1'b0, 32'hFFFFFFF0,   32'h10,       4,  32'hFFFFFFF0,   32'h10, 32'h0FFFFFFF, 32'd0,        1'b0, 1'b0, 8);
      run_op("sm7_m2",   1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, 1,  32'd7,          32'd2,  32'd3,        32'hFFFFFFFF, 1'b0, 1'b0, 5);
      run_op("sm14_7",   1'b1, 32'hFFFFFFF2,   32'd7,        2,  32'd14,         32'd7,  32'hFFFFFFFE, 32'd0,        1'b0, 1'b0, 6);
      run_op("divzero",  1'b0, 32'h1234,       32'd0,        1,  32'd0,          32'd0,  32'hFFFFFFFF, 32'h1234,     1'b1, 1'b0, 3);
      run_op("u50_5",    1'b0, 32'd50,         32'd5,        1,  32'd50,         32'd5,  32'd10,       32'd0,        1'b0, 1'b0, 5);
      run_op("timeout",  1'b0, 32'd9,          32'd3,        0,  32'd9,          32'd3,  32'd10,       32'd0,        1'b0, 1'b1, -1);
      run_op("u9_2",     1'b0, 32'd9,          32'd2,        1,  32'd9,          32'd2,  32'd4,        32'd1,        1'b0, 1'b0, 5);

      // start held high: ignored in the done cycle, accepted the cycle after
      first_cs = -1; second_cs = -1;
      @(negedge clock);
      signed_op = 1'b0; dividend = 32'd21; divisor = 32'd4; core_n = 1; start = 1'b1;
      @(posedge clock);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clock);
         if (core_start) begin
            if (first_cs < 0) first_cs = c;
            else if (second_cs < 0) second_cs = c;
         end
      end
      start = 1'b0;
      check("held_first_cs", 32'(first_cs), 32'd2);
      check("held_second_cs", 32'(second_cs), 32'd8);
      repeat (6) @(negedge clock);
      check("held_lo", lo, 32'd5);
      check("held_hi", hi, 32'd1);

      // Reset during WAIT with start held, then a late core_done
      @(negedge clock);
      dividend = 32'd100; divisor = 32'd7; core_n = 0; start = 1'b1;
      cs0 = cs_count;
      repeat (10) @(negedge clock);
      check("hold_one_accept", 32'(cs_count - cs0), 32'd1);
      check("hold_busy", 32'(busy), 32'd1);
      #2 clear_n = 1'b0;
      #1;
      check("mid_rst_hi", hi, 32'd0);
      check("mid_rst_lo", lo, 32'd0);
      check("mid_rst_core_dvd", core_dividend, 32'd0);
      check("mid_rst_core_dvs", core_divisor, 32'd0);
      check("mid_rst_ctl", {28'd0, core_start, busy, done, timeout_err}, 32'd0);
      check("mid_rst_dz", 32'(div_zero), 32'd0);
      start = 1'b0;
      @(posedge clock);
      #1 clear_n = 1'b1;
      inject = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         check("late_done_busy", {30'd0, busy, done}, 32'd0);
      end
      check("late_done_lo", lo, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
